vga_scan_ctrl: RTL and testbench
================================

Name: vga_scan_ctrl

Overview:
- VGA raster timing generator and pixel output stage for 640x480@60 Hz from a 25 MHz pixel clock.
- Drives x_pos/y_pos scan coordinates into a page renderer and accepts the renderer's registered 12-bit pixel_data back.
- Aligns hsync/vsync/blanking to the renderer latency and drives the 4:4:4 DAC pins with blanking enforced.
- Sits between all page_* renderers and the board VGA connector.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- PIX_LATENCY, 1, renderer clocks from x_pos/y_pos to pixel_data (>=1)

Ports:
- vga_clk  in  1  pixel clock, 25 MHz; all logic on rising edge
- vga_rst  in  1  synchronous active-high reset
- pixel_data  in  12  renderer colour: [11:8] blue, [7:4] green, [3:0] red
- x_pos  out  10  current horizontal count h_cnt (0..H_TOTAL-1)
- y_pos  out  10  current vertical count v_cnt (0..V_TOTAL-1)
- vga_r  out  4  red DAC
- vga_g  out  4  green DAC
- vga_b  out  4  blue DAC
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync
- frame_start  out  1  one-cycle pulse at scan position (0,0)
- line_start  out  1  one-cycle pulse at h_cnt==0

Behaviour:
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525).
- h_cnt:
  - Increments every clock.
  - At H_TOTAL-1 it wraps to 0, and v_cnt increments.
  - When v_cnt is at V_TOTAL-1 on that same wrap, v_cnt wraps to 0.
- x_pos/y_pos are h_cnt/v_cnt directly (stage 0). They are not clamped in blanking; renderers range-check.
- Stage-0 decode:
  - active0 = (h_cnt < H_VIS) && (v_cnt < V_VIS).
  - hs0 asserted for H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC (656..751).
  - vs0 asserted for V_VIS+V_FP <= v_cnt < V_VIS+V_FP+V_SYNC (490..491).
  - vs0 changes with v_cnt, i.e. at h_cnt==0.
- Alignment pipeline: active0/hs0/vs0 pass through PIX_LATENCY register stages, giving active_d/hs_d/vs_d.
- Output register (one more clock):
  - {vga_b,vga_g,vga_r} <= active_d ? pixel_data : 0.
  - vga_hs <= hs_d ? SYNC_POL : ~SYNC_POL; vga_vs likewise.
  - Total latency from x_pos/y_pos to pins is PIX_LATENCY+1 clocks, for data and syncs alike.
- frame_start = (h_cnt==0 && v_cnt==0) && !vga_rst; line_start = (h_cnt==0) && !vga_rst. Both are stage-0, not delayed.
- Blanking: DAC outputs are 0 whenever active_d==0, regardless of pixel_data.
- Reset:
  - While vga_rst is high, at each clock edge: h_cnt=v_cnt=0, all pipeline stages inactive with syncs deasserted, DAC outputs=0, vga_hs=vga_vs=~SYNC_POL.
  - The first cycle after release has x_pos=0, y_pos=0 and frame_start=1.
  - Reset asserted mid-frame aborts the frame immediately. No partial sync pulse persists beyond the reset edge; the pipeline is flushed, not drained.
- Width rule: all comparisons are 10-bit unsigned. Parameters must give H_TOTAL, V_TOTAL <= 1024.
- pixel_data is sampled only at the output register. No handshake: the renderer must meet PIX_LATENCY exactly.

Test Plan:
- Reset release, then run 800 clocks:
  - x_pos counts 0..799 then returns to 0.
  - y_pos steps 0->1 in the cycle x_pos returns to 0.
  - line_start pulses exactly at x_pos==0.
- Run one full frame (420000 clocks):
  - frame_start pulses once per 420000 clocks.
  - y_pos max is 524.
  - vga_vs is low for exactly 1600 clocks, starting PIX_LATENCY+1 clocks after (x=0, y=490).
- hsync timing with PIX_LATENCY=1:
  - vga_hs falls 2 clocks after x_pos==656.
  - vga_hs rises 2 clocks after x_pos==752; pulse width 96.
- Renderer stub returning pixel_data = {2'b0, x_pos[9:0]} registered once (latency 1):
  - At pin time, {vga_b,vga_g,vga_r} equals the x of 2 clocks earlier for x<640.
  - Pins are 0 for x>=640 and for y>=480, even with pixel_data forced to 12'hfff.
- Assert vga_rst for 3 clocks at (x=700, y=491), i.e. during both syncs:
  - On the first reset edge vga_hs=vga_vs=1 and the DAC outputs are 0.
  - After release, x_pos=0, y_pos=0 and frame_start=1.
- Instance with PIX_LATENCY=3 and a 3-stage renderer stub: a colour bar at x 10..90 (12'hf00) appears on the pins exactly over sync-relative pixels 10..90.

Source files
------------

// File: rtl/vga_scan_ctrl.sv
// rtl/vga_scan_ctrl.sv - VGA raster timing generator with latency-aligned, blanked pixel output stage
module vga_scan_ctrl #(
    parameter int   H_VIS       = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_VIS       = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   PIX_LATENCY = 1
) (
    input  logic        vga_clk,
    input  logic        vga_rst,
    input  logic [11:0] pixel_data,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_start,
    output logic        line_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // All raster comparisons are 10-bit unsigned; totals must stay within 1024.
    localparam logic [9:0] L_H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] L_V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] L_H_VIS  = 10'(H_VIS);
    localparam logic [9:0] L_V_VIS  = 10'(V_VIS);
    localparam logic [9:0] L_HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] L_HS_END = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] L_VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] L_VS_END = 10'(V_VIS + V_FP + V_SYNC);

    logic [9:0]             r_h_cnt;
    logic [9:0]             r_v_cnt;
    logic                   w_active0;
    logic                   w_hs0;
    logic                   w_vs0;
    logic [PIX_LATENCY-1:0] r_active_pipe;
    logic [PIX_LATENCY-1:0] r_hs_pipe;
    logic [PIX_LATENCY-1:0] r_vs_pipe;
    logic                   w_active_d;
    logic                   w_hs_d;
    logic                   w_vs_d;
    logic [11:0]            r_rgb;
    logic                   r_hs;
    logic                   r_vs;

    // Raster counters: h wraps every line, v advances on the h wrap and wraps per frame
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == L_H_LAST) begin
            r_h_cnt <= '0;
            if (r_v_cnt == L_V_LAST) begin
                r_v_cnt <= '0;
            end else begin
                r_v_cnt <= r_v_cnt + 10'd1;
            end
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    // Stage-0 decode, aligned with the coordinates handed to the renderer
    assign w_active0 = (r_h_cnt < L_H_VIS) && (r_v_cnt < L_V_VIS);
    assign w_hs0     = (r_h_cnt >= L_HS_BEG) && (r_h_cnt < L_HS_END);
    assign w_vs0     = (r_v_cnt >= L_VS_BEG) && (r_v_cnt < L_VS_END);

    // Delay line matching the renderer latency; reset flushes it to inactive
    generate
        if (PIX_LATENCY == 1) begin : g_lat1
            always_ff @(posedge vga_clk) begin
                if (vga_rst) begin
                    r_active_pipe <= '0;
                    r_hs_pipe     <= '0;
                    r_vs_pipe     <= '0;
                end else begin
                    r_active_pipe <= w_active0;
                    r_hs_pipe     <= w_hs0;
                    r_vs_pipe     <= w_vs0;
                end
            end
        end else begin : g_latn
            always_ff @(posedge vga_clk) begin
                if (vga_rst) begin
                    r_active_pipe <= '0;
                    r_hs_pipe     <= '0;
                    r_vs_pipe     <= '0;
                end else begin
                    r_active_pipe <= {r_active_pipe[PIX_LATENCY-2:0], w_active0};
                    r_hs_pipe     <= {r_hs_pipe[PIX_LATENCY-2:0], w_hs0};
                    r_vs_pipe     <= {r_vs_pipe[PIX_LATENCY-2:0], w_vs0};
                end
            end
        end
    endgenerate

    assign w_active_d = r_active_pipe[PIX_LATENCY-1];
    assign w_hs_d     = r_hs_pipe[PIX_LATENCY-1];
    assign w_vs_d     = r_vs_pipe[PIX_LATENCY-1];

    // Pin register: colour gated by blanking, syncs mapped to the board polarity
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            r_rgb <= '0;
            r_hs  <= ~SYNC_POL;
            r_vs  <= ~SYNC_POL;
        end else begin
            r_rgb <= w_active_d ? pixel_data : 12'h000;
            r_hs  <= w_hs_d ? SYNC_POL : ~SYNC_POL;
            r_vs  <= w_vs_d ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign x_pos       = r_h_cnt;
    assign y_pos       = r_v_cnt;
    assign vga_b       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_r       = r_rgb[3:0];
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign frame_start = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0) && !vga_rst;
    assign line_start  = (r_h_cnt == 10'd0) && !vga_rst;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb/tb_vga_scan_ctrl.sv - directed bench for vga_scan_ctrl (full-size line timing and short-frame instance)
`timescale 1ns/1ps
module tb_vga_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    logic        force_a = 1'b0;
    logic        force_b = 1'b0;
    logic [11:0] pd_a = 12'h000;
    logic [11:0] pd_b = 12'h000;
    logic [11:0] s1_b = 12'h000;
    logic [11:0] s2_b = 12'h000;

    logic [9:0]  x_a, y_a, x_b, y_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic        hs_a, vs_a, fs_a, ls_a, hs_b, vs_b, fs_b, ls_b;
    logic [11:0] rgb_a, rgb_b;

    int n_vec = 0;
    int n_err = 0;

    assign rgb_a = {b_a, g_a, r_a};
    assign rgb_b = {b_b, g_b, r_b};

    always #20 clk = ~clk;

    // Full 640x480 timing, renderer latency 1
    vga_scan_ctrl #(.PIX_LATENCY(1)) u_a (
        .vga_clk(clk), .vga_rst(rst_a), .pixel_data(pd_a),
        .x_pos(x_a), .y_pos(y_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .vga_hs(hs_a), .vga_vs(vs_a), .frame_start(fs_a), .line_start(ls_a)
    );

    // Full line timing, 8-line frame (4 visible, vsync on lines 5..6), renderer latency 3
    vga_scan_ctrl #(.V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIX_LATENCY(3)) u_b (
        .vga_clk(clk), .vga_rst(rst_b), .pixel_data(pd_b),
        .x_pos(x_b), .y_pos(y_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .vga_hs(hs_b), .vga_vs(vs_b), .frame_start(fs_b), .line_start(ls_b)
    );

    // Renderer stubs
    always @(posedge clk) begin
        pd_a <= force_a ? 12'hfff : {2'b00, x_a};
        s1_b <= force_b ? 12'hfff : ((x_b >= 10'd10 && x_b <= 10'd90) ? 12'hf00 : 12'h050);
        s2_b <= s1_b;
        pd_b <= s2_b;
    end

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (x_a !== 10'd0)   begin n_err++; $display("FAIL rst_x got=%0d exp=0", x_a); end
        n_vec++; if (hs_a !== 1'b1)   begin n_err++; $display("FAIL rst_hs got=%b exp=1", hs_a); end
        n_vec++; if (vs_a !== 1'b1)   begin n_err++; $display("FAIL rst_vs got=%b exp=1", vs_a); end
        n_vec++; if (rgb_a !== 12'h0) begin n_err++; $display("FAIL rst_rgb got=%h exp=000", rgb_a); end
        n_vec++; if (fs_a !== 1'b0)   begin n_err++; $display("FAIL rst_fs got=%b exp=0", fs_a); end
        n_vec++; if (ls_a !== 1'b0)   begin n_err++; $display("FAIL rst_ls got=%b exp=0", ls_a); end
        rst_a = 1'b0;
        #1;
        n_vec++; if (x_a !== 10'd0 || y_a !== 10'd0) begin n_err++; $display("FAIL rel_xy got=%0d,%0d exp=0,0", x_a, y_a); end
        n_vec++; if (fs_a !== 1'b1) begin n_err++; $display("FAIL rel_fs got=%b exp=1", fs_a); end
    endtask

    task automatic test_line;
        int xd;
        logic [11:0] e_rgb;
        logic e_hs;
        for (int k = 0; k <= 801; k++) begin
            if (k > 0) @(negedge clk);
            n_vec++; if (x_a !== 10'(k % 800)) begin n_err++; $display("FAIL line_x k=%0d got=%0d exp=%0d", k, x_a, k % 800); end
            n_vec++; if (y_a !== ((k >= 800) ? 10'd1 : 10'd0)) begin n_err++; $display("FAIL line_y k=%0d got=%0d", k, y_a); end
            n_vec++; if (ls_a !== (k % 800 == 0)) begin n_err++; $display("FAIL line_ls k=%0d got=%b", k, ls_a); end
            n_vec++; if (fs_a !== (k == 0)) begin n_err++; $display("FAIL line_fs k=%0d got=%b", k, fs_a); end
            if (k >= 2) begin
                xd = k - 2;
                e_rgb = (xd < 640) ? 12'(xd) : 12'h000;
                e_hs = !(xd >= 656 && xd < 752);
            end else begin
                e_rgb = 12'h000;
                e_hs = 1'b1;
            end
            n_vec++; if (rgb_a !== e_rgb) begin n_err++; $display("FAIL line_rgb k=%0d got=%h exp=%h", k, rgb_a, e_rgb); end
            n_vec++; if (hs_a !== e_hs) begin n_err++; $display("FAIL line_hs k=%0d got=%b exp=%b", k, hs_a, e_hs); end
            n_vec++; if (vs_a !== 1'b1) begin n_err++; $display("FAIL line_vs k=%0d got=%b exp=1", k, vs_a); end
        end
    endtask

    task automatic test_force_blank;
        int lx;
        logic [11:0] e_rgb;
        for (int k = 802; k <= 1601; k++) begin
            @(negedge clk);
            if (k == 802) force_a = 1'b1;
            if (k >= 806) begin
                lx = k - 2 - 800;
                e_rgb = (lx < 640) ? 12'hfff : 12'h000;
                n_vec++; if (rgb_a !== e_rgb) begin n_err++; $display("FAIL force_rgb k=%0d got=%h exp=%h", k, rgb_a, e_rgb); end
                n_vec++; if (hs_a !== !(lx >= 656 && lx < 752)) begin n_err++; $display("FAIL force_hs k=%0d got=%b", k, hs_a); end
            end
        end
        force_a = 1'b0;
    endtask

    task automatic test_frame_lat3;
        int j, jx, jy, fs_cnt, vs_low, y_max;
        logic [11:0] e_rgb;
        logic e_hs, e_vs;
        fs_cnt = 0; vs_low = 0; y_max = 0;
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        for (int k = 0; k <= 11100; k++) begin
            if (k > 0) @(negedge clk);
            n_vec++; if (x_b !== 10'(k % 800) || y_b !== 10'((k / 800) % 8)) begin n_err++; $display("FAIL frm_xy k=%0d got=%0d,%0d", k, x_b, y_b); end
            n_vec++; if (fs_b !== (k % 6400 == 0)) begin n_err++; $display("FAIL frm_fs k=%0d got=%b", k, fs_b); end
            fs_cnt += int'(fs_b);
            if (int'(y_b) > y_max) y_max = int'(y_b);
            j = k - 4;
            if (j < 0) begin
                e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1;
            end else begin
                jx = j % 800;
                jy = (j / 800) % 8;
                e_hs = !(jx >= 656 && jx < 752);
                e_vs = !(jy == 5 || jy == 6);
                if (jx < 640 && jy < 4)
                    e_rgb = (j >= 6402) ? 12'hfff : ((jx >= 10 && jx <= 90) ? 12'hf00 : 12'h050);
                else
                    e_rgb = 12'h000;
            end
            if (k < 6404 && vs_b === 1'b0) vs_low++;
            n_vec++; if (rgb_b !== e_rgb) begin n_err++; $display("FAIL frm_rgb k=%0d got=%h exp=%h", k, rgb_b, e_rgb); end
            n_vec++; if (hs_b !== e_hs) begin n_err++; $display("FAIL frm_hs k=%0d got=%b exp=%b", k, hs_b, e_hs); end
            n_vec++; if (vs_b !== e_vs) begin n_err++; $display("FAIL frm_vs k=%0d got=%b exp=%b", k, vs_b, e_vs); end
            if (k == 6402) force_b = 1'b1;
        end
        n_vec++; if (fs_cnt != 2) begin n_err++; $display("FAIL frm_fs_count got=%0d exp=2", fs_cnt); end
        n_vec++; if (vs_low != 1600) begin n_err++; $display("FAIL frm_vs_width got=%0d exp=1600", vs_low); end
        n_vec++; if (y_max != 7) begin n_err++; $display("FAIL frm_y_max got=%0d exp=7", y_max); end
    endtask

    task automatic test_reset_mid_sync;
        rst_b = 1'b1;
        @(negedge clk);
        n_vec++; if (hs_b !== 1'b1 || vs_b !== 1'b1) begin n_err++; $display("FAIL mid_syncs got=%b%b exp=11", hs_b, vs_b); end
        n_vec++; if (rgb_b !== 12'h0) begin n_err++; $display("FAIL mid_rgb got=%h exp=000", rgb_b); end
        n_vec++; if (x_b !== 10'd0 || y_b !== 10'd0) begin n_err++; $display("FAIL mid_xy got=%0d,%0d exp=0,0", x_b, y_b); end
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        #1;
        n_vec++; if (x_b !== 10'd0 || y_b !== 10'd0) begin n_err++; $display("FAIL mid_rel_xy got=%0d,%0d exp=0,0", x_b, y_b); end
        n_vec++; if (fs_b !== 1'b1) begin n_err++; $display("FAIL mid_rel_fs got=%b exp=1", fs_b); end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            n_vec++; if (hs_b !== 1'b1 || vs_b !== 1'b1 || rgb_b !== 12'h0) begin
                n_err++; $display("FAIL mid_flush k=%0d got hs=%b vs=%b rgb=%h exp 1,1,000", k, hs_b, vs_b, rgb_b);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_line;
        test_force_blank;
        test_frame_lat3;
        test_reset_mid_sync;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
